mdu_seq: RTL and testbench

Sequential multiply/divide unit for the MIPS datapath. It executes MULT, MULTU, DIV and DIVU iteratively and owns the architectural HI/LO registers. The combinational ALU cannot produce 64-bit products or quotient/remainder pairs in one cycle, so the decode stage routes these instructions here. While the unit works it raises a busy signal for the hazard unit, and it serves MFHI/MFLO reads and MTHI/MTLO writes.

---
 rtl/mdu_seq.sv | 195 +++++++++++++++++++
 tb/tb_mdu_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// mdu_seq: iterative multiply/divide unit that owns the HI/LO registers.
//
// It executes MULT/MULTU/DIV/DIVU in a fixed 33 cycles: 32 shift-add or
// restoring-divide iterations, then one sign-fix/write-back cycle. MTHI and
// MTLO writes are accepted only while the unit is idle.
//
// Ports
//   clk, reset         rising-edge clock, synchronous active-high reset
//   start, opt, a, b   operation request, sampled only in IDLE
//                      (opt: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   hi_we, lo_we, wdata MTHI/MTLO write port, honoured only in IDLE
//   busy               an operation is in flight (state != IDLE)
//   done               one-cycle pulse after HI/LO take a result
//   div_by_zero        valid with done; DIV/DIVU with b == 0
//   hi, lo             architectural HI/LO registers
//   dbg_state          current FSM state (0 IDLE, 1 CALC, 2 FIX)
//
// Handshake: start is a request with no ready; it is accepted on any edge
// where the unit is in IDLE (busy low, including the cycle done is high)
// and silently dropped otherwise. done/div_by_zero are single-cycle
// strobes, and hi/lo are stable whenever busy is low.
module mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       opt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [5:0]           cnt_q, cnt_d;
  logic [1:0]           opt_q, opt_d;
  // Multiply: {partial product, multiplier}. Divide: {remainder, quotient}.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  // Multiplicand for multiply, divisor for divide (magnitude for signed ops).
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 res_sign_q, res_sign_d;
  logic                 rem_sign_q, rem_sign_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;

  // Datapath temporaries
  logic                 signed_in;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH:0]     mul_wide;
  logic [2*WIDTH-1:0]   div_shift;
  logic [WIDTH:0]       div_trial;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    opt_d      = opt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    res_sign_d = res_sign_q;
    rem_sign_d = rem_sign_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    dbz_d      = 1'b0;

    signed_in  = ~opt[0];
    mag_a      = (signed_in && a[WIDTH-1]) ? (~a + 1'b1) : a;
    mag_b      = (signed_in && b[WIDTH-1]) ? (~b + 1'b1) : b;

    // One shift-add step: add into the upper half with a carry bit, then
    // shift the whole 65-bit value right by one.
    mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                 (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_wide   = {mul_sum, acc_q[WIDTH-1:0]};

    // One restoring-divide step: shift, then trial-subtract the divisor;
    // bit WIDTH of the trial difference is the borrow.
    div_shift  = acc_q << 1;
    div_trial  = {1'b0, div_shift[2*WIDTH-1:WIDTH]} - {1'b0, opnd_q};

    prod_fix   = (~opt_q[0] && res_sign_q) ? (~acc_q + 1'b1) : acc_q;
    quo_fix    = (~opt_q[0] && res_sign_q) ? (~acc_q[WIDTH-1:0] + 1'b1)
                                            : acc_q[WIDTH-1:0];
    rem_fix    = (~opt_q[0] && rem_sign_q) ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1)
                                            : acc_q[2*WIDTH-1:WIDTH];

    case (state_q)
      ST_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          state_d    = ST_CALC;
          opt_d      = opt;
          cnt_d      = '0;
          res_sign_d = a[WIDTH-1] ^ b[WIDTH-1];
          rem_sign_d = a[WIDTH-1];
          if (opt[1]) begin
            acc_d  = {{WIDTH{1'b0}}, mag_a};
            opnd_d = mag_b;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, mag_b};
            opnd_d = mag_a;
          end
        end
      end

      ST_CALC: begin
        if (opt_q[1]) begin
          acc_d = div_shift;
          if (!div_trial[WIDTH]) begin
            acc_d[2*WIDTH-1:WIDTH] = div_trial[WIDTH-1:0];
            acc_d[0]               = 1'b1;
          end
        end else begin
          acc_d = mul_wide[2*WIDTH:1];
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST_ITER) state_d = ST_FIX;
      end

      ST_FIX: begin
        if (opt_q[1]) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        // A zero divisor latches as zero in both the signed and unsigned case.
        dbz_d   = opt_q[1] && (opnd_q == '0);
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      opt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      res_sign_q <= 1'b0;
      rem_sign_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      opt_q      <= opt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      res_sign_q <= res_sign_d;
      rem_sign_q <= rem_sign_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Testbench for mdu_seq: randomized and directed MULT/MULTU/DIV/DIVU
// operations scored against an arithmetic reference model.
module tb_mdu_seq;

  localparam int W = 65;  // {div_by_zero, hi, lo}

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  opt = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;
  logic [1:0]  dbg_state;

  int cmp_cnt = 0;
  int err_cnt = 0;
  logic [W-1:0] exp_q[$];

  mdu_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .opt(opt), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model(input logic [1:0] op,
                                         input logic [31:0] x,
                                         input logic [31:0] y);
    longint sx, sy, sq, sr;
    logic [63:0] p;
    logic [31:0] q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (op)
      2'b00: begin
        p = 64'(sx * sy);
        return {1'b0, p};
      end
      2'b01: begin
        p = {32'b0, x} * {32'b0, y};
        return {1'b0, p};
      end
      2'b10: begin
        if (y == 0) begin
          // Raw quotient all ones, raw remainder |x|; both re-signed by x's sign.
          q = x[31] ? 32'h0000_0001 : 32'hFFFF_FFFF;
          r = x;
          return {1'b1, r, q};
        end
        sq = sx / sy;   // 64-bit, so -2^31 / -1 is safe and truncates below
        sr = sx % sy;
        q = sq[31:0];
        r = sr[31:0];
        return {1'b0, r, q};
      end
      default: begin
        if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
        q = x / y;
        r = x % y;
        return {1'b0, r, q};
      end
    endcase
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("result_hi", 64'(hi), 64'(e[63:32]));
        check("result_lo", 64'(lo), 64'(e[31:0]));
        check("result_dbz", 64'(div_by_zero), 64'(e[64]));
      end
    end else if (!reset && div_by_zero) begin
      check("dbz_without_done", 64'(div_by_zero), 64'd0);
    end
  end

  // ---------------- driver tasks ----------------
  // Raise start now; it is sampled at the next posedge (E0).
  task automatic issue(input logic [1:0] op, input logic [31:0] x,
                       input logic [31:0] y);
    opt = op; a = x; b = y; start = 1'b1;
    exp_q.push_back(model(op, x, y));
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; opt = 2'($urandom_range(0, 3));
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] x,
                          input logic [31:0] y);
    @(posedge clk); #1;
    issue(op, x, y);
  endtask

  // Count busy cycles until done is seen, bounded at 40 cycles.
  task automatic wait_done(output int nbusy, output bit got);
    nbusy = 0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) nbusy++;
    end
    if (!got) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] x,
                        input logic [31:0] y);
    int n;
    bit got;
    start_op(op, x, y);
    wait_done(n, got);
    if (got) check("busy_len", 64'(n), 64'd33);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    bit got;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int sel;
    logic [63:0] saved_hi;

    // Pin the model with hand-computed results.
    check("model_mult_neg3x5", 64'(model(2'b00, 32'hFFFF_FFFD, 32'd5)),
          64'hFFFF_FFFF_FFFF_FFF1);
    check("model_multu_max", 64'(model(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF)),
          64'hFFFF_FFFE_0000_0001);
    check("model_mult_m1m1", 64'(model(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF)),
          64'h0000_0000_0000_0001);
    check("model_div_neg7_2", 64'(model(2'b10, 32'hFFFF_FFF9, 32'd2)),
          64'hFFFF_FFFF_FFFF_FFFD);
    check("model_divu_100_7", 64'(model(2'b11, 32'd100, 32'd7)),
          64'h0000_0002_0000_000E);
    check("model_div_ovf", 64'(model(2'b10, 32'h8000_0000, 32'hFFFF_FFFF)),
          64'h0000_0000_8000_0000);
    check("model_divu_by0", 64'(model(2'b11, 32'd100, 32'd0) >> 32),
          64'h1_0000_0064);

    // Reset
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_dbz", 64'(div_by_zero), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);

    // Directed test-plan operations
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5);
    check("lit_mult_hi", 64'(hi), 64'hFFFF_FFFF);
    check("lit_mult_lo", 64'(lo), 64'hFFFF_FFF1);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op(2'b11, 32'd100, 32'd7);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'b11, 32'd100, 32'd0);
    check("lit_divu0_lo", 64'(lo), 64'hFFFF_FFFF);
    check("lit_divu0_dbz", 64'(div_by_zero), 64'd1);
    run_op(2'b11, 32'd10, 32'd5);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0);
    run_op(2'b10, 32'd7, 32'd0);

    // start re-pulsed mid-CALC plus lo_we during busy: both ignored
    start_op(2'b00, 32'd1234567, 32'hFFFF_FFA7);
    repeat (5) @(posedge clk);
    #1 start = 1'b1; opt = 2'b11; a = 32'd999; b = 32'd3;
    lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0; lo_we = 1'b0;
    wait_done(n, got);

    // start on the done cycle is accepted
    issue(2'b11, 32'hCAFE_F00D, 32'd13);
    wait_done(n, got);
    if (got) check("b2b_busy_len", 64'(n), 64'd33);

    // MTLO in IDLE
    saved_hi = 64'(hi);
    @(posedge clk); #1;
    lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    lo_we = 1'b0;
    @(negedge clk);
    check("mtlo_idle_lo", 64'(lo), 64'hDEAD_BEEF);
    check("mtlo_idle_hi", 64'(hi), saved_hi);

    // start together with MTHI: write visible, then overwritten by result
    @(posedge clk); #1;
    hi_we = 1'b1; wdata = 32'h1357_9BDF;
    issue(2'b01, 32'd6, 32'd7);
    hi_we = 1'b0;
    @(negedge clk);
    check("mthi_with_start", 64'(hi), 64'h1357_9BDF);
    wait_done(n, got);

    // reset mid-CALC aborts
    start_op(2'b11, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    got = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    check("abort_no_done", 64'(got), 64'd0);
    run_op(2'b10, 32'hFFFF_FC18, 32'd7);

    // Randomized operations, sometimes issued on the done cycle
    for (int k = 0; k < 40; k++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = 32'($urandom_range(0, 200)); rb = 32'($urandom_range(1, 20)); end
        3: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
        default: ;
      endcase
      if ($urandom_range(0, 1) == 1) issue(rop, ra, rb);
      else start_op(rop, ra, rb);
      wait_done(n, got);
      if (got) check("rand_busy_len", 64'(n), 64'd33);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
